schoening_solver: RTL and testbench
===================================

Name: schoening_solver

Overview:
Parametrised hardware 3SAT solver using Schoening's randomized local search. It generalises the fixed 4-variable/4-clause prototype: a clause memory is loaded at run time, clauses hold three signed literals, and the block has explicit restart and flip budgets. A start/done handshake reports SAT with an assignment, or UNSAT-by-exhaustion. It sits under the solver top level and is fed by the host-side clause loader.

Parameters:
N, 16, number of variables (power of 2, 4..64)
M, 32, clause slots (power of 2, 4..256)
FLIPS, 48, flips per try before restart (default 3N)
TRIES, 64, restarts before giving up (>=1)
SEED, 32'hACE1_2468, LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
load_valid  in  1  write clause slot load_idx this cycle
load_idx  in  log2(M)  clause slot index
load_en  in  1  slot enable written with the clause
load_clause  in  3*(log2(N)+1)  literal k at [k*(L)+:L], L=log2(N)+1; bit L-1 = negate, low bits = variable index
start  in  1  begin solve (sampled in IDLE only)
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the solve ends
sat  out  1  valid with done, held until next start: 1 = satisfying assignment found
solution  out  N  final assignment, valid with done, held until next start
tries_used  out  log2(TRIES)+1  number of tries started, held until next start

Behaviour:
- Reset: all outputs 0, FSM = IDLE, all clause enables cleared, LFSR = SEED, counters 0. Reset mid-solve aborts immediately; no done pulse.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, advances every cycle in every state.
- Clause memory: writes accepted only in IDLE; load_valid in any other state is ignored. Disabled slots count as satisfied. A literal is true when assign[var] XOR negate = 1. A clause is satisfied when any of its 3 literals is true. Fewer than 3 literals are encoded by duplicating a literal.
- all_sat = AND over slots of (satisfied OR not enabled), evaluated combinationally from the current assignment.
- FSM:
  - IDLE: start=1 -> INIT, clears tries_used, sat, and solution.
  - INIT: assign <= lfsr[N-1:0]; flip_cnt <= 0; tries_used++; -> EVAL.
  - EVAL:
    - all_sat -> DONE with sat=1.
    - Else if flip_cnt==FLIPS: tries_used==TRIES -> DONE with sat=0; otherwise -> INIT.
    - Else -> FLIP.
  - FLIP:
    - Clause choice: rotate the unsatisfied-enabled vector right by r=lfsr[log2(M)-1:0], then take the lowest set bit; clause = (bit + r) mod M.
    - Literal choice: k = lfsr[log2(M)+1:log2(M)]. If k==3, stay in FLIP (re-draw next cycle, flip_cnt unchanged). Otherwise toggle assign[var_k], flip_cnt++, -> EVAL.
  - DONE: done=1 for one cycle; solution <= assign; busy=0; -> IDLE.
- Latency: minimum 3 cycles start->done (IDLE, INIT, EVAL sat, DONE pulse on the 4th edge). Each non-rerolled flip costs 2 cycles.
- start while busy is ignored. start and load_valid in the same IDLE cycle: the write happens and the solve starts; the solve uses the new clause.
- A formula with no enabled clauses is satisfied on the first EVAL (sat=1, solution = initial random assignment).
- flip_cnt is wide enough to hold FLIPS. tries_used saturates at TRIES.

Test Plan:
- Reset, then idle 10 cycles -> busy=done=sat=0, solution=0, tries_used=0; start with zero clauses -> done in the 4th cycle, sat=1, tries_used=1.
- Load slot 0 = (x0,x0,x0), slot 1 = (~x1,~x1,~x1), start -> done with sat=1, solution[0]=1, solution[1]=0, tries_used<=TRIES.
- N=4, M=4, TRIES=2, FLIPS=3; slots (x0,x0,x0) and (~x0,~x0,~x0) -> done with sat=0, tries_used=2, exactly one done pulse; cycle count matches the reference model driven by the same LFSR.
- Prototype formula (x0|~x1), (x1|~x2), (x2|~x3), (x3|~x0) as 3-literal clauses -> sat=1 with x0=x1=x2=x3; check the solution against all enabled clauses.
- load_valid pulsed while busy with a contradicting clause -> the solve result is unchanged; after done, a readback solve shows the write was dropped.
- Assert reset during FLIP mid-solve -> no done pulse; all outputs 0 next cycle; enables cleared, so a new start returns sat=1 immediately.

Source files
------------

// File: rtl/schoening_solver.sv
// -----------------------------------------------------------------------------
// schoening_solver
//
// 3SAT solver using Schoening's randomized local search. The host loads
// clauses into M slots while the solver is idle. Each clause holds three
// signed literals. A solve proceeds as a series of tries. Each try starts
// from a random assignment and performs up to FLIPS random flips, each on a
// variable taken from an unsatisfied clause. The solve ends with SAT once
// every enabled clause holds. It ends with UNSAT once TRIES tries have used
// up their flips.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high; aborts any solve in progress
//   load_valid_i   write clause slot load_idx_i this cycle (IDLE only)
//   load_idx_i     clause slot index
//   load_en_i      enable bit stored with the clause
//   load_clause_i  literal k at [k*L +: L]; bit L-1 = negate, low bits = var
//   start_i        begin a solve (sampled in IDLE only)
//   busy_o         high from the cycle after start until done
//   done_o         one-cycle pulse when the solve ends
//   sat_o          1 = satisfying assignment found (held until next start)
//   solution_o     final assignment (held until next start)
//   tries_used_o   number of tries started (held until next start)
// -----------------------------------------------------------------------------
module schoening_solver #(
    parameter int          N     = 16,
    parameter int          M     = 32,
    parameter int          FLIPS = 48,
    parameter int          TRIES = 64,
    parameter logic [31:0] SEED  = 32'hACE1_2468,
    localparam int         VW    = $clog2(N),
    localparam int         L     = VW + 1,
    localparam int         MW    = $clog2(M),
    localparam int         TW    = $clog2(TRIES) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid_i,
    input  logic [MW-1:0]    load_idx_i,
    input  logic             load_en_i,
    input  logic [3*L-1:0]   load_clause_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             sat_o,
    output logic [N-1:0]     solution_o,
    output logic [TW-1:0]    tries_used_o
);

    localparam int          FW   = $clog2(FLIPS + 1);
    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_EVAL,
        S_FLIP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     lfsr_q, lfsr_d;
    logic [N-1:0]    asg_q, asg_d;
    logic [FW-1:0]   flip_q, flip_d;
    logic [TW-1:0]   tries_q, tries_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sat_q, sat_d;
    logic [N-1:0]    sol_q, sol_d;
    logic [M-1:0]    en_q, en_d;

    // Clause storage. The satisfaction check needs every slot at once, so
    // the slots are held in registers, not in a RAM with one read port.
    logic [3*L-1:0]  clause_mem [M];

    logic            load_we;
    assign load_we = load_valid_i && (state_q == S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset && load_we) begin
            clause_mem[load_idx_i] <= load_clause_i;
        end
    end

    // -------------------------------------------------------------------------
    // Clause evaluation against the current assignment
    // -------------------------------------------------------------------------
    logic [VW-1:0]   lit_var [M][3];
    logic [M-1:0]    unsat;
    logic            all_sat;

    for (genvar gi = 0; gi < M; gi++) begin : g_slot
        logic [2:0] lit_true;
        for (genvar gk = 0; gk < 3; gk++) begin : g_lit
            assign lit_var[gi][gk] = clause_mem[gi][gk*L +: VW];
            assign lit_true[gk]    = asg_q[lit_var[gi][gk]] ^ clause_mem[gi][gk*L + L - 1];
        end
        // Disabled slots never count as unsatisfied
        assign unsat[gi] = en_q[gi] & ~(|lit_true);
    end

    assign all_sat = ~(|unsat);

    // -------------------------------------------------------------------------
    // Random clause and literal choice
    // -------------------------------------------------------------------------
    // Rotating the unsatisfied vector right by r and taking the lowest set
    // bit selects the first unsatisfied clause at or after slot r, wrapping.
    logic [MW-1:0]   rot_r;
    logic [2*M-1:0]  unsat_dbl;
    logic [M-1:0]    unsat_rot;
    logic [MW-1:0]   pick_off;
    logic [MW-1:0]   pick_clause;
    logic [1:0]      lit_k;
    logic [1:0]      lit_k_eff;
    logic [VW-1:0]   flip_var;

    assign rot_r     = lfsr_q[MW-1:0];
    assign unsat_dbl = {unsat, unsat};
    assign unsat_rot = unsat_dbl[rot_r +: M];

    always_comb begin
        pick_off = '0;
        // Descending scan so the lowest set bit wins
        for (int i = M - 1; i >= 0; i--) begin
            if (unsat_rot[i]) begin
                pick_off = MW'(i);
            end
        end
    end

    // Addition wraps modulo M because M is a power of two
    assign pick_clause = pick_off + rot_r;
    assign lit_k       = lfsr_q[MW+1:MW];
    // k == 3 is a re-draw and toggles nothing. Clamp it so the index stays
    // in range.
    assign lit_k_eff   = (lit_k == 2'd3) ? 2'd0 : lit_k;
    assign flip_var    = lit_var[pick_clause][lit_k_eff];

    // Initial assignment of a try: LFSR bits, repeated when N exceeds 32
    logic [N-1:0]    init_word;
    always_comb begin
        init_word = '0;
        for (int i = 0; i < N; i++) begin
            init_word[i] = lfsr_q[i % 32];
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        asg_d   = asg_q;
        flip_d  = flip_q;
        tries_d = tries_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sat_d   = sat_q;
        sol_d   = sol_q;
        en_d    = en_q;

        if (load_we) begin
            en_d[load_idx_i] = load_en_i;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_INIT;
                    tries_d = '0;
                    sat_d   = 1'b0;
                    sol_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_INIT: begin
                asg_d   = init_word;
                flip_d  = '0;
                tries_d = (tries_q == TW'(TRIES)) ? tries_q : tries_q + 1'b1;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                // Results are registered on entry to DONE. The assignment is
                // therefore already stable on the cycle done is high.
                if (all_sat) begin
                    state_d = S_DONE;
                    sat_d   = 1'b1;
                    sol_d   = asg_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (flip_q == FW'(FLIPS)) begin
                    if (tries_q == TW'(TRIES)) begin
                        state_d = S_DONE;
                        sat_d   = 1'b0;
                        sol_d   = asg_q;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_INIT;
                    end
                end else begin
                    state_d = S_FLIP;
                end
            end
            S_FLIP: begin
                if (lit_k != 2'd3) begin
                    asg_d[flip_var] = ~asg_q[flip_var];
                    flip_d          = flip_q + 1'b1;
                    state_d         = S_EVAL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            asg_q   <= '0;
            flip_q  <= '0;
            tries_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            sol_q   <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            asg_q   <= asg_d;
            flip_q  <= flip_d;
            tries_q <= tries_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            sol_q   <= sol_d;
            en_q    <= en_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign sat_o        = sat_q;
    assign solution_o   = sol_q;
    assign tries_used_o = tries_q;

endmodule

// File: tb/tb_schoening_solver.sv
module tb_schoening_solver;

    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam int BN = 16, BM = 32, BF = 48, BT = 64;
    localparam int SN = 4,  SM = 4,  SF = 3,  ST = 2;

    typedef struct { int cyc; bit sat; logic [63:0] sol; int tu; } exp_t;
    typedef struct { int cyc; bit sat; logic [63:0] sol; int tu;
                     bit busy_ok; bit timeout; int pulses; } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        b_lv = 1'b0, b_en = 1'b0, b_start = 1'b0;
    logic [4:0]  b_idx = '0;
    logic [14:0] b_cl = '0;
    logic        b_busy, b_done, b_sat;
    logic [15:0] b_sol;
    logic [6:0]  b_tu;

    // Small instance: N=4, M=4, FLIPS=3, TRIES=2
    logic        s_lv = 1'b0, s_en = 1'b0, s_start = 1'b0;
    logic [1:0]  s_idx = '0;
    logic [8:0]  s_cl = '0;
    logic        s_busy, s_done, s_sat;
    logic [3:0]  s_sol;
    logic [1:0]  s_tu;

    schoening_solver dut_big (
        .clk(clk), .reset(reset),
        .load_valid_i(b_lv), .load_idx_i(b_idx), .load_en_i(b_en),
        .load_clause_i(b_cl), .start_i(b_start),
        .busy_o(b_busy), .done_o(b_done), .sat_o(b_sat),
        .solution_o(b_sol), .tries_used_o(b_tu)
    );

    schoening_solver #(.N(SN), .M(SM), .FLIPS(SF), .TRIES(ST), .SEED(SEED)) dut_small (
        .clk(clk), .reset(reset),
        .load_valid_i(s_lv), .load_idx_i(s_idx), .load_en_i(s_en),
        .load_clause_i(s_cl), .start_i(s_start),
        .busy_o(s_busy), .done_o(s_done), .sat_o(s_sat),
        .solution_o(s_sol), .tries_used_o(s_tu)
    );

    function automatic logic [31:0] lfsr_adv(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    // Reference LFSR, reset and advanced exactly like the design's
    logic [31:0] lfsr_m;
    always @(posedge clk) begin
        if (reset) lfsr_m <= SEED;
        else       lfsr_m <= lfsr_adv(lfsr_m);
    end

    // Shadow copy of what each instance's clause memory should hold
    int sh_var [2][32][3];
    bit sh_neg [2][32][3];
    bit sh_en  [2][32];

    exp_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    function automatic bit clause_unsat(input int sel, input int c, input logic [63:0] a);
        bit any = 1'b0;
        if (!sh_en[sel][c]) return 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (a[sh_var[sel][c][k]] ^ sh_neg[sel][c][k]) any = 1'b1;
        end
        return !any;
    endfunction

    function automatic int count_unsat(input int sel, input logic [63:0] a);
        int cnt = 0;
        for (int c = 0; c < (sel ? SM : BM); c++) begin
            if (clause_unsat(sel, c, a)) cnt++;
        end
        return cnt;
    endfunction

    function automatic logic [63:0] init_assign(input int n, input logic [31:0] lf);
        logic [63:0] a = '0;
        for (int i = 0; i < n; i++) a[i] = lf[i % 32];
        return a;
    endfunction

    // Cycle-stepped reference solve. l0 is the LFSR value in the cycle where
    // start is sampled (cycle 0). The result cyc is the cycle in which done
    // is high.
    function automatic void model(input int sel, input logic [31:0] l0, output int cyc,
                                  output bit sat, output logic [63:0] sol, output int tu);
        int n  = sel ? SN : BN;
        int m  = sel ? SM : BM;
        int fl = sel ? SF : BF;
        int tr = sel ? ST : BT;
        int mw = sel ? 2 : 5;
        logic [31:0] lf;
        logic [63:0] a;
        int fc, t, k, r, c;
        cyc = -1; sat = 1'b0; sol = '0;
        t = 1; lf = lfsr_adv(l0); a = init_assign(n, lf); fc = 0; tu = 1;
        while (t < 60000) begin
            t++; lf = lfsr_adv(lf);                       // EVAL cycle
            if (count_unsat(sel, a) == 0) begin
                cyc = t + 1; sat = 1'b1; sol = a; return;
            end
            if (fc == fl) begin
                if (tu == tr) begin
                    cyc = t + 1; sat = 1'b0; sol = a; return;
                end
                t++; lf = lfsr_adv(lf);                   // INIT cycle
                a = init_assign(n, lf); fc = 0; tu++;
            end else begin
                do begin
                    t++; lf = lfsr_adv(lf);               // FLIP cycle(s)
                    k = int'((lf >> mw) & 32'd3);
                end while (k == 3);
                r = int'(lf & 32'(m - 1));
                for (int j = 0; j < m; j++) begin
                    c = (r + j) % m;
                    if (clause_unsat(sel, c, a)) begin
                        a[sh_var[sel][c][k]] = ~a[sh_var[sel][c][k]];
                        break;
                    end
                end
                fc++;
            end
        end
    endfunction

    // Drives a clause write for one cycle (the caller advances the clock)
    task automatic drive_load(input int sel, input int idx, input bit en,
                              input int v0, input bit n0, input int v1, input bit n1,
                              input int v2, input bit n2);
        if (sel == 0) begin
            b_lv = 1'b1; b_idx = 5'(idx); b_en = en;
            b_cl = {n2, 4'(v2), n1, 4'(v1), n0, 4'(v0)};
        end else begin
            s_lv = 1'b1; s_idx = 2'(idx); s_en = en;
            s_cl = {n2, 2'(v2), n1, 2'(v1), n0, 2'(v0)};
        end
        sh_en[sel][idx] = en;
        sh_var[sel][idx][0] = v0; sh_neg[sel][idx][0] = n0;
        sh_var[sel][idx][1] = v1; sh_neg[sel][idx][1] = n1;
        sh_var[sel][idx][2] = v2; sh_neg[sel][idx][2] = n2;
    endtask

    task automatic load_slot(input int sel, input int idx, input bit en,
                             input int v0, input bit n0, input int v1, input bit n1,
                             input int v2, input bit n2);
        drive_load(sel, idx, en, v0, n0, v1, n1, v2, n2);
        @(negedge clk);
        b_lv = 1'b0; s_lv = 1'b0;
    endtask

    task automatic start_solve(input int sel);
        exp_t e;
        if (sel == 0) b_start = 1'b1; else s_start = 1'b1;
        model(sel, lfsr_m, e.cyc, e.sat, e.sol, e.tu);
        sb.push_back(e);
    endtask

    // Runs the clock until done, gathering what the DUT reports
    task automatic wait_done(input int sel, input int cyc0, output obs_t o);
        int cyc = cyc0;
        logic d, bz;
        o.cyc = -1; o.sat = 1'b0; o.sol = '0; o.tu = 0;
        o.busy_ok = 1'b1; o.timeout = 1'b0; o.pulses = 0;
        forever begin
            @(negedge clk);
            b_start = 1'b0; b_lv = 1'b0; s_start = 1'b0; s_lv = 1'b0;
            cyc++;
            d  = sel ? s_done : b_done;
            bz = sel ? s_busy : b_busy;
            if (d === 1'b1) begin
                o.cyc = cyc;
                o.sat = sel ? s_sat : b_sat;
                o.sol = sel ? 64'(s_sol) : 64'(b_sol);
                o.tu  = sel ? int'(s_tu) : int'(b_tu);
                o.pulses = 1;
                if (bz !== 1'b0) o.busy_ok = 1'b0;
                break;
            end
            if (bz !== 1'b1) o.busy_ok = 1'b0;
            if (cyc - cyc0 > 30000) begin
                o.timeout = 1'b1;
                break;
            end
        end
        repeat (2) begin
            @(negedge clk);
            if ((sel ? s_done : b_done) === 1'b1) o.pulses++;
        end
    endtask

    task automatic test_reset;
        obs_t o; exp_t e;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_assert++; if ({b_busy, b_done, b_sat, b_sol, b_tu} !== 26'd0) begin n_fail++;
            $display("FAIL reset_big_outputs: got %h required 0", {b_busy, b_done, b_sat, b_sol, b_tu}); end
        n_assert++; if ({s_busy, s_done, s_sat, s_sol, s_tu} !== 9'd0) begin n_fail++;
            $display("FAIL reset_small_outputs: got %h required 0", {s_busy, s_done, s_sat, s_sol, s_tu}); end
        start_solve(0);
        wait_done(0, 0, o);
        e = sb.pop_front();
        $display("empty formula: done cycle %0d sat %0d tries %0d solution %h", o.cyc, o.sat, o.tu, o.sol);
        n_assert++; if (o.timeout) begin n_fail++; $display("FAIL empty_timeout: no done within budget"); end
        n_assert++; if (o.cyc !== 3) begin n_fail++; $display("FAIL empty_latency: got %0d required 3", o.cyc); end
        n_assert++; if (o.sat !== 1'b1) begin n_fail++; $display("FAIL empty_sat: got %0d required 1", o.sat); end
        n_assert++; if (o.tu !== 1) begin n_fail++; $display("FAIL empty_tries: got %0d required 1", o.tu); end
        n_assert++; if (o.sol !== e.sol) begin n_fail++; $display("FAIL empty_solution: got %h required %h", o.sol, e.sol); end
        n_assert++; if (!o.busy_ok || o.pulses !== 1) begin n_fail++;
            $display("FAIL empty_handshake: busy_ok %0d pulses %0d required 1 1", o.busy_ok, o.pulses); end
    endtask

    task automatic test_unit_clauses;
        obs_t o; exp_t e;
        load_slot(0, 0, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        load_slot(0, 1, 1'b1, 1, 1'b1, 1, 1'b1, 1, 1'b1);
        start_solve(0);
        wait_done(0, 0, o);
        e = sb.pop_front();
        $display("unit clauses: done cycle %0d sat %0d tries %0d solution %h", o.cyc, o.sat, o.tu, o.sol);
        n_assert++; if (o.timeout || o.cyc !== e.cyc) begin n_fail++;
            $display("FAIL unit_cycles: got %0d required %0d", o.cyc, e.cyc); end
        n_assert++; if (o.sat !== 1'b1) begin n_fail++; $display("FAIL unit_sat: got %0d required 1", o.sat); end
        n_assert++; if (o.sol[1:0] !== 2'b01) begin n_fail++; $display("FAIL unit_x1x0: got %b required 01", o.sol[1:0]); end
        n_assert++; if (o.sol !== e.sol) begin n_fail++; $display("FAIL unit_solution: got %h required %h", o.sol, e.sol); end
        n_assert++; if (o.tu !== e.tu || o.tu > BT) begin n_fail++; $display("FAIL unit_tries: got %0d required %0d", o.tu, e.tu); end
    endtask

    task automatic test_unsat_small;
        obs_t o; exp_t e;
        load_slot(1, 0, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        load_slot(1, 1, 1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b1);
        start_solve(1);
        wait_done(1, 0, o);
        e = sb.pop_front();
        $display("small unsat: done cycle %0d sat %0d tries %0d solution %h", o.cyc, o.sat, o.tu, o.sol);
        n_assert++; if (o.timeout || o.cyc !== e.cyc) begin n_fail++;
            $display("FAIL unsat_cycles: got %0d required %0d", o.cyc, e.cyc); end
        n_assert++; if (o.sat !== 1'b0) begin n_fail++; $display("FAIL unsat_sat: got %0d required 0", o.sat); end
        n_assert++; if (o.tu !== ST) begin n_fail++; $display("FAIL unsat_tries: got %0d required %0d", o.tu, ST); end
        n_assert++; if (o.pulses !== 1 || !o.busy_ok) begin n_fail++;
            $display("FAIL unsat_handshake: pulses %0d busy_ok %0d required 1 1", o.pulses, o.busy_ok); end
        n_assert++; if (o.sol !== e.sol) begin n_fail++; $display("FAIL unsat_solution: got %h required %h", o.sol, e.sol); end
    endtask

    task automatic test_prototype;
        obs_t o; exp_t e;
        // (x0|~x1) (x1|~x2) (x2|~x3) (x3|~x0), each padded with a duplicate
        load_slot(0, 0, 1'b1, 0, 1'b0, 1, 1'b1, 0, 1'b0);
        load_slot(0, 1, 1'b1, 1, 1'b0, 2, 1'b1, 1, 1'b0);
        load_slot(0, 2, 1'b1, 2, 1'b0, 3, 1'b1, 2, 1'b0);
        load_slot(0, 3, 1'b1, 3, 1'b0, 0, 1'b1, 3, 1'b0);
        start_solve(0);
        wait_done(0, 0, o);
        e = sb.pop_front();
        $display("prototype: done cycle %0d sat %0d tries %0d solution %h", o.cyc, o.sat, o.tu, o.sol);
        n_assert++; if (o.timeout || o.cyc !== e.cyc) begin n_fail++;
            $display("FAIL proto_cycles: got %0d required %0d", o.cyc, e.cyc); end
        n_assert++; if (o.sat !== 1'b1) begin n_fail++; $display("FAIL proto_sat: got %0d required 1", o.sat); end
        n_assert++; if (o.sol[3:0] !== 4'h0 && o.sol[3:0] !== 4'hF) begin n_fail++;
            $display("FAIL proto_equal_vars: got %b required 0000 or 1111", o.sol[3:0]); end
        n_assert++; if (count_unsat(0, o.sol) !== 0) begin n_fail++;
            $display("FAIL proto_clauses: got %0d unsatisfied required 0", count_unsat(0, o.sol)); end
        n_assert++; if (o.sol !== e.sol || o.tu !== e.tu) begin n_fail++;
            $display("FAIL proto_result: got %h/%0d required %h/%0d", o.sol, o.tu, e.sol, e.tu); end
    endtask

    task automatic test_drop_busy;
        obs_t o; exp_t e;
        load_slot(0, 0, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        load_slot(0, 1, 1'b1, 1, 1'b1, 1, 1'b1, 1, 1'b1);
        load_slot(0, 2, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        load_slot(0, 3, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        start_solve(0);
        @(negedge clk);
        // Cycle 1 (busy): a contradicting write and a second start, both ignored
        b_lv = 1'b1; b_idx = 5'd2; b_en = 1'b1; b_cl = {1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0};
        b_start = 1'b1;
        wait_done(0, 1, o);
        e = sb.pop_front();
        $display("write while busy: done cycle %0d sat %0d tries %0d solution %h", o.cyc, o.sat, o.tu, o.sol);
        n_assert++; if (o.timeout || o.cyc !== e.cyc) begin n_fail++;
            $display("FAIL busy_cycles: got %0d required %0d", o.cyc, e.cyc); end
        n_assert++; if (o.sat !== 1'b1 || o.sol !== e.sol) begin n_fail++;
            $display("FAIL busy_result: got %0d/%h required 1/%h", o.sat, o.sol, e.sol); end
        n_assert++; if (o.pulses !== 1) begin n_fail++; $display("FAIL busy_pulses: got %0d required 1", o.pulses); end
        start_solve(0);
        wait_done(0, 0, o);
        e = sb.pop_front();
        $display("readback: done cycle %0d sat %0d tries %0d solution %h", o.cyc, o.sat, o.tu, o.sol);
        n_assert++; if (o.timeout || o.cyc !== e.cyc) begin n_fail++;
            $display("FAIL readback_cycles: got %0d required %0d", o.cyc, e.cyc); end
        n_assert++; if (o.sat !== 1'b1 || o.sol[1:0] !== 2'b01) begin n_fail++;
            $display("FAIL readback_result: got %0d/%b required 1/01", o.sat, o.sol[1:0]); end
    endtask

    task automatic test_back_to_back;
        obs_t o; exp_t e;
        // Write slot 3 = ~x3 in the same cycle as start
        drive_load(0, 3, 1'b1, 3, 1'b1, 3, 1'b1, 3, 1'b1);
        start_solve(0);
        wait_done(0, 0, o);
        e = sb.pop_front();
        $display("load with start: done cycle %0d sat %0d tries %0d solution %h", o.cyc, o.sat, o.tu, o.sol);
        n_assert++; if (o.timeout || o.cyc !== e.cyc) begin n_fail++;
            $display("FAIL b2b_cycles: got %0d required %0d", o.cyc, e.cyc); end
        n_assert++; if (o.sat !== 1'b1 || o.sol[3] !== 1'b0 || o.sol[1:0] !== 2'b01) begin n_fail++;
            $display("FAIL b2b_result: got %0d/%b required 1/0x01", o.sat, o.sol[3:0]); end
        n_assert++; if (o.sol !== e.sol || o.tu !== e.tu) begin n_fail++;
            $display("FAIL b2b_model: got %h/%0d required %h/%0d", o.sol, o.tu, e.sol, e.tu); end
    endtask

    task automatic test_reset_flip;
        obs_t o; exp_t e;
        bit saw_done = 1'b0;
        // Small instance still holds x0 and ~x0, so cycle 3 is a FLIP
        s_start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            s_start = 1'b0;
            if (s_done !== 1'b0) saw_done = 1'b1;
        end
        reset = 1'b1;
        @(negedge clk);
        n_assert++; if (saw_done || {s_busy, s_done, s_sat, s_sol, s_tu} !== 9'd0) begin n_fail++;
            $display("FAIL abort_small: saw_done %0d outputs %h required 0 0", saw_done, {s_busy, s_done, s_sat, s_sol, s_tu}); end
        n_assert++; if ({b_busy, b_done, b_sat, b_sol, b_tu} !== 26'd0) begin n_fail++;
            $display("FAIL abort_big: got %h required 0", {b_busy, b_done, b_sat, b_sol, b_tu}); end
        reset = 1'b0;
        for (int s = 0; s < 2; s++) for (int c = 0; c < 32; c++) sh_en[s][c] = 1'b0;
        start_solve(1);
        wait_done(1, 0, o);
        e = sb.pop_front();
        $display("after abort: done cycle %0d sat %0d tries %0d solution %h", o.cyc, o.sat, o.tu, o.sol);
        n_assert++; if (o.timeout || o.cyc !== 3 || o.sat !== 1'b1 || o.tu !== 1) begin n_fail++;
            $display("FAIL abort_restart: got cyc %0d sat %0d tries %0d required 3 1 1", o.cyc, o.sat, o.tu); end
        n_assert++; if (o.sol !== e.sol) begin n_fail++;
            $display("FAIL abort_solution: got %h required %h", o.sol, e.sol); end
        start_solve(0);
        wait_done(0, 0, o);
        e = sb.pop_front();
        $display("after abort big: done cycle %0d sat %0d tries %0d solution %h", o.cyc, o.sat, o.tu, o.sol);
        n_assert++; if (o.cyc !== 3 || o.sat !== 1'b1 || o.sol !== e.sol) begin n_fail++;
            $display("FAIL abort_big_restart: got %0d/%0d/%h required 3/1/%h", o.cyc, o.sat, o.sol, e.sol); end
    endtask

    initial begin
        test_reset();
        test_unit_clauses();
        test_unsat_small();
        test_prototype();
        test_drop_busy();
        test_back_to_back();
        test_reset_flip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
